// File: rtl/uart_mmio_responder_pkg.sv
// uart_mmio_responder_pkg
//   Shared definitions for the UART MMIO responder: register offsets inside
//   the 16-byte window, the default window base and the address-hit helper.
package uart_mmio_responder_pkg;

   localparam logic [31:0] UART_BASE_ADDR = 32'h8000_0000;

   localparam logic [3:0] UART_TX_STATUS = 4'h0;
   localparam logic [3:0] UART_RX_STATUS = 4'h4;
   localparam logic [3:0] UART_TX_DATA   = 4'h8;
   localparam logic [3:0] UART_RX_DATA   = 4'hC;

   // A hit needs the upper 28 bits to match the window and a word-aligned address.
   function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
      return (addr[31:4] == base[31:4]) && (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/uart_mmio_responder_if.sv
// uart_mmio_responder_if
//   Bundles the CPU load/store strobes and the UART transmitter/receiver
//   byte handshakes.
//   slave  : responder side (receives CPU access, drives UART TX, accepts RX)
//   master : CPU + UART model side
interface uart_mmio_responder_if;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic        WE;
   logic        RE;
   logic [31:0] ReadData;
   logic [7:0]  DataIn;
   logic        DataInValid;
   logic        DataInReady;
   logic [7:0]  DataOut;
   logic        DataOutValid;
   logic        DataOutReady;

   modport slave (
      input  Addr, WriteData, WE, RE, DataInReady, DataOut, DataOutValid,
      output ReadData, DataIn, DataInValid, DataOutReady
   );

   modport master (
      output Addr, WriteData, WE, RE, DataInReady, DataOut, DataOutValid,
      input  ReadData, DataIn, DataInValid, DataOutReady
   );
endinterface

// File: rtl/uart_mmio_responder_tx_fifo.sv
// uart_tx_fifo
//   Synchronous FIFO feeding the UART transmitter. Pointers carry one extra
//   wrap bit so full and empty are distinguishable without a counter.
//   Ports:
//     Clock, Reset : clock, synchronous active-high reset
//     push, din    : write request and data (accepted when not full, or when
//                    full with a simultaneous pop)
//     pop          : read request (ignored when empty)
//     dout         : head entry, combinational from registered state
//     full, empty  : status
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             wr_en;
   logic             rd_en;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign dout  = mem_q[rd_ptr_q[AW-1:0]];

   assign rd_en = pop && !empty;
   // When full, the pop frees the head slot on this same edge, so the
   // incoming byte lands exactly where the head is being read out.
   assign wr_en = push && (!full || rd_en);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = din;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge Clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder
//   CPU-side responder for the UART MMIO window. Serves status/data loads
//   with one cycle of latency, queues stored bytes into a TX FIFO that drains
//   into the UART transmitter, and holds one received byte until read.
//   Ports:
//     Clock, Reset : clock, synchronous active-high reset
//     bus (slave)  : CPU Addr/WriteData/WE/RE/ReadData, UART TX
//                    DataIn/DataInValid/DataInReady, UART RX
//                    DataOut/DataOutValid/DataOutReady
//   Register map (offset from BASE_ADDR):
//     0x0 load : {30'b0, tx_ovf, ~full}; load clears tx_ovf
//     0x4 load : {31'b0, rx_valid}
//     0x8 store: push WriteData[7:0] into TX FIFO
//     0xC load : rx_data when rx_valid (then clears rx_valid), else 0
module uart_mmio_responder
   import uart_mmio_responder_pkg::*;
#(
   parameter int          TX_DEPTH  = 4,
   parameter logic [31:0] BASE_ADDR = UART_BASE_ADDR
) (
   input  logic                 Clock,
   input  logic                 Reset,
   uart_mmio_responder_if.slave bus
);

   logic        hit;
   logic [3:0]  offset;
   logic        load_hit;
   logic        store_hit;
   logic        push;
   logic        pop;
   logic        full;
   logic        empty;
   logic [7:0]  fifo_dout;

   logic        tx_ovf_q, tx_ovf_d;
   logic        rx_valid_q, rx_valid_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic [31:0] read_data_q, read_data_d;
   logic [31:0] load_value;

   assign hit       = addr_hit(bus.Addr, BASE_ADDR);
   assign offset    = bus.Addr[3:0];
   assign load_hit  = bus.RE && hit;
   assign store_hit = bus.WE && hit;

   assign push = store_hit && (offset == UART_TX_DATA);
   assign pop  = bus.DataInValid && bus.DataInReady;

   uart_tx_fifo #(
      .WIDTH (8),
      .DEPTH (TX_DEPTH)
   ) u_tx_fifo (
      .Clock (Clock),
      .Reset (Reset),
      .push  (push),
      .din   (bus.WriteData[7:0]),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (full),
      .empty (empty)
   );

   assign bus.DataIn       = fifo_dout;
   assign bus.DataInValid  = !empty;
   assign bus.DataOutReady = !rx_valid_q;

   // Load data is taken from pre-edge state, so a concurrent store or
   // receive is not visible in this load's result.
   always_comb begin
      load_value = 32'h0;
      if (hit) begin
         unique case (offset)
            UART_TX_STATUS: load_value = {30'b0, tx_ovf_q, !full};
            UART_RX_STATUS: load_value = {31'b0, rx_valid_q};
            UART_RX_DATA:   load_value = rx_valid_q ? {24'b0, rx_data_q} : 32'h0;
            default:        load_value = 32'h0;
         endcase
      end
   end

   always_comb begin
      read_data_d = read_data_q;
      tx_ovf_d    = tx_ovf_q;
      rx_valid_d  = rx_valid_q;
      rx_data_d   = rx_data_q;

      if (bus.RE) begin
         read_data_d = load_value;
      end

      if (load_hit && (offset == UART_TX_STATUS)) begin
         tx_ovf_d = 1'b0;
      end
      // Overflow set wins over a same-cycle clear by a status load.
      if (push && full && !pop) begin
         tx_ovf_d = 1'b1;
      end

      if (load_hit && (offset == UART_RX_DATA) && rx_valid_q) begin
         rx_valid_d = 1'b0;
      end
      // DataOutReady is ~rx_valid, so a capture never collides with a clear.
      if (bus.DataOutValid && !rx_valid_q) begin
         rx_valid_d = 1'b1;
         rx_data_d  = bus.DataOut;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         read_data_q <= 32'h0;
         tx_ovf_q    <= 1'b0;
         rx_valid_q  <= 1'b0;
         rx_data_q   <= 8'h0;
      end else begin
         read_data_q <= read_data_d;
         tx_ovf_q    <= tx_ovf_d;
         rx_valid_q  <= rx_valid_d;
         rx_data_q   <= rx_data_d;
      end
   end

   assign bus.ReadData = read_data_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
module tb_uart_mmio_responder;

   logic Clock;
   logic Reset;
   int   checks;
   int   errors;

   uart_mmio_responder_if bus ();

   uart_mmio_responder #(
      .TX_DEPTH  (4),
      .BASE_ADDR (32'h8000_0000)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // All drive tasks start and end at 1 time unit after a rising edge.
   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic cpu_load(input logic [31:0] addr, output logic [31:0] data);
      bus.Addr = addr;
      bus.RE   = 1'b1;
      tick();
      bus.RE   = 1'b0;
      data     = bus.ReadData;
   endtask

   task automatic cpu_store(input logic [31:0] addr, input logic [7:0] data);
      bus.Addr      = addr;
      bus.WriteData = {24'hABCDEF, data};
      bus.WE        = 1'b1;
      tick();
      bus.WE        = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      Reset = 1'b1;
      tick();
      tick();
      Reset = 1'b0;
      checks++;
      if (bus.DataInValid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b want 0", bus.DataInValid);
      end
      checks++;
      if (bus.DataOutReady !== 1'b1) begin
         errors++;
         $display("FAIL reset_rx_ready: got %b want 1", bus.DataOutReady);
      end
      checks++;
      if (bus.ReadData !== 32'h0) begin
         errors++;
         $display("FAIL reset_read_data: got %h want 0", bus.ReadData);
      end
      cpu_load(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL reset_status: got %h want 00000001", rd);
      end
   endtask

   task automatic test_tx_single();
      bus.DataInReady = 1'b0;
      cpu_store(32'h8000_0008, 8'h41);
      checks++;
      if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'h41) begin
         errors++;
         $display("FAIL tx_single: got valid=%b data=%h want valid=1 data=41",
                  bus.DataInValid, bus.DataIn);
      end
      bus.DataInReady = 1'b1;
      tick();
      bus.DataInReady = 1'b0;
      checks++;
      if (bus.DataInValid !== 1'b0) begin
         errors++;
         $display("FAIL tx_single_drain: got valid=%b want 0", bus.DataInValid);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      bus.DataInReady = 1'b0;
      for (int i = 1; i <= 5; i++) cpu_store(32'h8000_0008, 8'(i));
      cpu_load(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'h2) begin
         errors++;
         $display("FAIL ovf_status: got %h want 00000002", rd);
      end
      cpu_load(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL ovf_cleared: got %h want 00000000", rd);
      end
      bus.DataInReady = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'(i)) begin
            errors++;
            $display("FAIL ovf_drain[%0d]: got valid=%b data=%h want valid=1 data=%h",
                     i, bus.DataInValid, bus.DataIn, 8'(i));
         end
         tick();
      end
      bus.DataInReady = 1'b0;
      checks++;
      if (bus.DataInValid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_empty: got valid=%b want 0", bus.DataInValid);
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] rd;
      logic [7:0]  exp_q [4];
      exp_q = '{8'h12, 8'h13, 8'h14, 8'h77};
      bus.DataInReady = 1'b0;
      for (int i = 0; i < 4; i++) cpu_store(32'h8000_0008, 8'h11 + 8'(i));
      // FIFO is full: push 0x77 while 0x11 pops.
      bus.DataInReady = 1'b1;
      cpu_store(32'h8000_0008, 8'h77);
      bus.DataInReady = 1'b0;
      cpu_load(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL full_pop_status: got %h want 00000000", rd);
      end
      bus.DataInReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.DataInValid !== 1'b1 || bus.DataIn !== exp_q[i]) begin
            errors++;
            $display("FAIL full_pop_drain[%0d]: got valid=%b data=%h want valid=1 data=%h",
                     i, bus.DataInValid, bus.DataIn, exp_q[i]);
         end
         tick();
      end
      bus.DataInReady = 1'b0;
      cpu_load(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL full_pop_after: got %h want 00000001", rd);
      end
   endtask

   task automatic test_rx();
      logic [31:0] rd;
      bus.DataOut      = 8'h5A;
      bus.DataOutValid = 1'b1;
      tick();
      bus.DataOutValid = 1'b0;
      bus.DataOut      = 8'h00;
      cpu_load(32'h8000_0004, rd);
      checks++;
      if (rd !== 32'h1 || bus.DataOutReady !== 1'b0) begin
         errors++;
         $display("FAIL rx_status_full: got rd=%h ready=%b want rd=00000001 ready=0",
                  rd, bus.DataOutReady);
      end
      cpu_load(32'h8000_000C, rd);
      checks++;
      if (rd !== 32'h5A) begin
         errors++;
         $display("FAIL rx_data: got %h want 0000005a", rd);
      end
      cpu_load(32'h8000_0004, rd);
      checks++;
      if (rd !== 32'h0 || bus.DataOutReady !== 1'b1) begin
         errors++;
         $display("FAIL rx_status_empty: got rd=%h ready=%b want rd=00000000 ready=1",
                  rd, bus.DataOutReady);
      end
      cpu_load(32'h8000_000C, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rx_data_empty: got %h want 00000000", rd);
      end
   endtask

   task automatic test_rx_same_cycle();
      logic [31:0] rd;
      // Load 0xC while a byte is being captured: load sees rx_valid=0.
      bus.DataOut      = 8'hC3;
      bus.DataOutValid = 1'b1;
      cpu_load(32'h8000_000C, rd);
      bus.DataOutValid = 1'b0;
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL rx_same_load: got %h want 00000000", rd);
      end
      cpu_load(32'h8000_000C, rd);
      checks++;
      if (rd !== 32'hC3) begin
         errors++;
         $display("FAIL rx_same_capture: got %h want 000000c3", rd);
      end
   endtask

   task automatic test_miss();
      logic [31:0] rd;
      cpu_load(32'h8000_0000, rd);
      cpu_load(32'h8000_0010, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL miss_load_10: got %h want 00000000", rd);
      end
      cpu_load(32'h8000_0000, rd);
      cpu_load(32'h9000_0008, rd);
      checks++;
      if (rd !== 32'h0) begin
         errors++;
         $display("FAIL miss_load_9: got %h want 00000000", rd);
      end
      bus.DataInReady = 1'b0;
      cpu_store(32'h8000_0010, 8'h99);
      cpu_store(32'h9000_0008, 8'h98);
      cpu_store(32'h8000_000A, 8'h97);
      cpu_store(32'h8000_0000, 8'h96);
      checks++;
      if (bus.DataInValid !== 1'b0) begin
         errors++;
         $display("FAIL miss_store: got valid=%b want 0", bus.DataInValid);
      end
      cpu_load(32'h8000_0000, rd);
      checks++;
      if (rd !== 32'h1) begin
         errors++;
         $display("FAIL miss_status: got %h want 00000001", rd);
      end
   endtask

   task automatic test_reset_mid();
      bus.DataInReady = 1'b0;
      for (int i = 0; i < 3; i++) cpu_store(32'h8000_0008, 8'hA0 + 8'(i));
      checks++;
      if (bus.DataInValid !== 1'b1 || bus.DataIn !== 8'hA0) begin
         errors++;
         $display("FAIL reset_mid_pre: got valid=%b data=%h want valid=1 data=a0",
                  bus.DataInValid, bus.DataIn);
      end
      bus.Addr = 32'h8000_0000;
      bus.RE   = 1'b1;
      Reset    = 1'b1;
      tick();
      bus.RE   = 1'b0;
      Reset    = 1'b0;
      checks++;
      if (bus.DataInValid !== 1'b0 || bus.ReadData !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid: got valid=%b rd=%h want valid=0 rd=00000000",
                  bus.DataInValid, bus.ReadData);
      end
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      Reset            = 1'b1;
      bus.Addr         = 32'h0;
      bus.WriteData    = 32'h0;
      bus.WE           = 1'b0;
      bus.RE           = 1'b0;
      bus.DataInReady  = 1'b0;
      bus.DataOut      = 8'h0;
      bus.DataOutValid = 1'b0;
      tick();
      test_reset();
      test_tx_single();
      test_overflow();
      test_full_pop();
      test_rx();
      test_rx_same_cycle();
      test_miss();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_mmio_responder.md
Name: uart_mmio_responder

Overview:
- CPU-side responder for the UART memory-mapped I/O window 0x8000_0000–0x8000_000C.
- Decodes CPU load/store strobes issued by the control path (REUART/WEUART) and serves status and data reads.
- Buffers transmit bytes in a small FIFO that drains into the UART transmitter.
- Holds one received byte from the UART receiver until the CPU reads it.

Parameters:
- TX_DEPTH, 4, transmit FIFO depth in bytes; power of 2, minimum 2.
- BASE_ADDR, 32'h8000_0000, base of the UART MMIO window; bits [3:0] select the register.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Addr  in  32  CPU data address for the current access.
- WriteData  in  32  CPU store data; only [7:0] is used.
- WE  in  1  store strobe (WEUART).
- RE  in  1  load strobe (REUART).
- ReadData  out  32  registered load data.
- DataIn  out  8  byte to the UART transmitter.
- DataInValid  out  1  transmit byte valid.
- DataInReady  in  1  UART transmitter can accept a byte.
- DataOut  in  8  byte from the UART receiver.
- DataOutValid  in  1  received byte valid.
- DataOutReady  out  1  responder can accept a received byte.

Behaviour:
- Hit = (Addr[31:4] == BASE_ADDR[31:4]) and Addr[1:0] == 0. Accesses that miss have no effect, and a load that misses returns 0.
- Register map for loads (offset -> ReadData):
  - 0x0: {30'b0, tx_ovf, ~full}
  - 0x4: {31'b0, rx_valid}
  - 0xC: {24'b0, rx_data} when rx_valid, else 0
  - 0x8: 0
- Register map for stores: only offset 0x8 is writable. A store there pushes WriteData[7:0] into the TX FIFO. Stores to any other offset are ignored.
- Load latency is 1 cycle: ReadData is registered on the edge after RE and holds its value until the next RE. With RE and WE high in the same cycle, WE takes effect and the load returns the pre-edge state.
- Side effects of loads:
  - Load of 0xC with rx_valid=1 clears rx_valid. rx_data is retained.
  - Load of 0x0 clears tx_ovf.
  - If tx_ovf is set in the same cycle that a 0x0 load clears it, set wins.
- TX FIFO behaviour:
  - Push at offset 0x8 when not full stores the byte.
  - Push when full and no pop in that cycle: the byte is dropped and tx_ovf is set.
  - Push when full with a simultaneous pop: the byte is accepted.
  - Pop occurs when DataInValid and DataInReady are both high.
  - DataInValid = ~empty, and DataIn = head entry; both are combinational from registered state.
  - Push to an empty FIFO: DataInValid rises on the next cycle (1-cycle fall-through). There is no bypass.
  - Pointers are log2(TX_DEPTH)+1 bits. Wrap is modulo 2*TX_DEPTH. full = MSBs differ and low bits equal; empty = pointers equal.
- RX path:
  - DataOutReady = ~rx_valid.
  - When DataOutValid and DataOutReady are both high, rx_data <= DataOut and rx_valid <= 1.
  - Load of 0xC in the same cycle as a receive: only possible when rx_valid=0, so the load returns 0 and the new byte is captured.
  - No overrun is possible; back-pressure is applied through DataOutReady.
- Reset values: FIFO empty, tx_ovf=0, rx_valid=0, rx_data=0, ReadData=0. Therefore DataInValid=0 and DataOutReady=1 one cycle after Reset.
- Reset mid-operation: FIFO contents are discarded and any in-flight load result is zeroed. A byte already accepted by the UART is unaffected.

Decomposition:
- Shared header uart_mmio.vh holds:
  - register offset constants: UART_TX_STATUS=4'h0, UART_RX_STATUS=4'h4, UART_TX_DATA=4'h8, UART_RX_DATA=4'hC
  - the BASE_ADDR default
- One sub-module: uart_tx_fifo, a synchronous FIFO.
  - Parameters: WIDTH=8 and DEPTH.
  - Ports: push, din, pop, dout, full, empty.

Test Plan:
- Reset, then load 0x8000_0000 -> ReadData=32'h1 on the next cycle; DataInValid=0; DataOutReady=1.
- Store 0x41 to 0x8000_0008 with DataInReady=0 -> DataInValid=1 and DataIn=8'h41 on the next cycle. Raise DataInReady for 1 cycle -> DataInValid=0.
- With DataInReady=0, store 5 bytes 0x01..0x05 -> 0x05 dropped; load 0x0 returns 32'h2. A second load of 0x0 returns 32'h0. Then drain -> bytes appear in order 0x01..0x04.
- With the FIFO full, store 0x77 in the same cycle as a pop -> tx_ovf stays 0; 0x77 later emerges after the remaining bytes.
- Drive DataOut=0x5A with DataOutValid=1 for 1 cycle:
  - load 0x4 -> 32'h1 and DataOutReady=0
  - load 0xC -> 32'h5A
  - load 0x4 -> 32'h0 and DataOutReady=1
- Loads and stores to 0x8000_0010 and 0x9000_0008 -> ReadData=0 and no state change. Asserting Reset with 3 bytes queued -> DataInValid=0 on the next cycle.
